// File: rtl/wrr_request_queue.sv
// -----------------------------------------------------------------------------
// wrr_request_queue
//
// Upstream feeder for a weighted round-robin arbiter. Each requestor owns a
// small FIFO. A queue's request line is high while it holds data. A legal
// one-hot grant pops that queue's head word, and the word appears on out_*
// one cycle later.
//
// Parameters
//   N      number of requestors (request/grant width)
//   DW     data word width
//   DEPTH  entries per queue (power of 2, >= 2)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous reset, active-high
//   push_valid  [N]     per-channel write strobe
//   push_data   [N*DW]  channel i word in bits [i*DW +: DW]
//   push_ready  [N]     channel i can accept a word (not full, not in reset)
//   request     [N]     channel i non-empty
//   grant       [N]     arbiter grant, one-hot or zero
//   out_valid           one-cycle pulse, popped word valid
//   out_data    [DW]    popped word (holds between pops)
//   out_id      [IW]    source channel of the popped word (holds between pops)
//   grant_err           one-cycle pulse, illegal grant seen
//   pop_count   [N*16]  saturating per-channel pop counters
//
// Optional feature: define WRR_QUEUE_STATS_EN to add pop_count and its
// counters. All other behaviour is the same with or without it.
// -----------------------------------------------------------------------------
module wrr_request_queue #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    push_valid,
    input  logic [N*DW-1:0] push_data,
    output logic [N-1:0]    push_ready,
    output logic [N-1:0]    request,
    input  logic [N-1:0]    grant,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [IW-1:0]   out_id,
`ifdef WRR_QUEUE_STATS_EN
    output logic [N*16-1:0] pop_count,
`endif
    output logic            grant_err
);

    localparam int AW = $clog2(DEPTH);
    // One extra pointer bit separates full from empty when addresses match.
    localparam int PW = AW + 1;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [N-1:0] v);
        return (v != {N{1'b0}}) && ((v & (v - N'(1))) == {N{1'b0}});
    endfunction

    logic [DW-1:0] mem_r [N][DEPTH];
    logic [PW-1:0] wr_ptr_r [N];
    logic [PW-1:0] rd_ptr_r [N];

    logic [N-1:0]  empty_s;
    logic [N-1:0]  full_s;
    logic [N-1:0]  push_fire_s;
    logic [N-1:0]  pop_s;
    logic [IW-1:0] grant_idx_s;
    logic          legal_s;
    logic          illegal_s;
    logic [DW-1:0] head_data_s;

    logic          out_valid_r;
    logic [DW-1:0] out_data_r;
    logic [IW-1:0] out_id_r;
    logic          grant_err_r;

    // Queue status from registered pointers; no same-cycle bypass.
    always_comb begin
        empty_s = {N{1'b0}};
        full_s  = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            empty_s[i] = (wr_ptr_r[i] == rd_ptr_r[i]);
            full_s[i]  = (wr_ptr_r[i][AW-1:0] == rd_ptr_r[i][AW-1:0]) &&
                         (wr_ptr_r[i][AW] != rd_ptr_r[i][AW]);
        end
    end

    assign push_ready  = ~full_s & {N{~reset}};
    assign request     = ~empty_s;
    assign push_fire_s = push_valid & push_ready;

    // Grant decode: a grant is legal only if one-hot and aimed at a non-empty queue.
    always_comb begin
        grant_idx_s = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx_s = IW'(i);
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
        legal_s     = is_onehot(grant) && !empty_s[grant_idx_s];
        illegal_s   = (grant != {N{1'b0}}) && !legal_s;
        pop_s       = legal_s ? grant : {N{1'b0}};
        head_data_s = mem_r[grant_idx_s][rd_ptr_r[grant_idx_s][AW-1:0]];
    end

    // Queue storage; intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push_fire_s[i]) begin
                mem_r[i][wr_ptr_r[i][AW-1:0]] <= push_data[i*DW +: DW];
            end
        end
    end

    // Read/write pointers; wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr_r[i] <= {PW{1'b0}};
                rd_ptr_r[i] <= {PW{1'b0}};
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push_fire_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PW'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PW'(1);
                end
            end
        end
    end

    // Downstream output register; data/id hold when nothing is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DW{1'b0}};
            out_id_r    <= {IW{1'b0}};
            grant_err_r <= 1'b0;
        end else begin
            out_valid_r <= legal_s;
            grant_err_r <= illegal_s;
            if (legal_s) begin
                out_data_r <= head_data_s;
                out_id_r   <= grant_idx_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_id    = out_id_r;
    assign grant_err = grant_err_r;

`ifdef WRR_QUEUE_STATS_EN
    logic [15:0] pop_cnt_r [N];

    // Saturating per-channel count of legal pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                pop_cnt_r[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pop_s[i] && (pop_cnt_r[i] != 16'hFFFF)) begin
                    pop_cnt_r[i] <= pop_cnt_r[i] + 16'h0001;
                end
            end
        end
    end

    // Pack counters onto the flat output bus.
    always_comb begin
        pop_count = {(N*16){1'b0}};
        for (int i = 0; i < N; i++) begin
            pop_count[i*16 +: 16] = pop_cnt_r[i];
        end
    end
`endif

endmodule

// File: tb/tb_wrr_request_queue.sv
// -----------------------------------------------------------------------------
// tb_wrr_request_queue
//
// Directed self-checking bench for wrr_request_queue (N=4, DW=8, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, so each check sees the state produced by the preceding edge.
// -----------------------------------------------------------------------------
module tb_wrr_request_queue;

    logic        clk;
    logic        reset;
    logic [3:0]  push_valid;
    logic [31:0] push_data;
    logic [3:0]  push_ready;
    logic [3:0]  request;
    logic [3:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        grant_err;
`ifdef WRR_QUEUE_STATS_EN
    logic [63:0] pop_count;
`endif

    int n_cmp;
    int n_err;

    wrr_request_queue #(.N(4), .DW(8), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .request    (request),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
`ifdef WRR_QUEUE_STATS_EN
        .pop_count  (pop_count),
`endif
        .grant_err  (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a single-channel push (other channels idle).
    task automatic set_push(input int ch, input logic [7:0] val);
        push_valid = 4'b0000;
        push_data  = 32'h0000_0000;
        push_valid[ch] = 1'b1;
        push_data[ch*8 +: 8] = val;
    endtask

    // Check one popped word.
    task automatic check_pop(input string tag, input logic [7:0] d, input logic [1:0] id);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"},  64'(out_data),  64'(d));
        check({tag, "_id"},    64'(out_id),    64'(id));
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        push_valid = 4'b0000;
        push_data  = 32'h0000_0000;
        grant      = 4'b0000;

        // ---- 1: reset for two clocks ----
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_ready",   64'(push_ready), 64'h0);
            check("rst_request", 64'(request),    64'h0);
            check("rst_valid",   64'(out_valid),  64'h0);
            check("rst_gerr",    64'(grant_err),  64'h0);
        end
        check("rst_data", 64'(out_data), 64'h0);
        check("rst_id",   64'(out_id),   64'h0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(push_ready), 64'hF);

        // ---- 2: two words through ch0 ----
        set_push(0, 8'hA1);
        tick();
        check("t2_req_a", 64'(request), 64'h1);
        set_push(0, 8'hA2);
        tick();
        push_valid = 4'b0000;
        grant      = 4'b0001;
        tick();
        check_pop("t2_pop1", 8'hA1, 2'd0);
        check("t2_req_b", 64'(request), 64'h1);
        tick();
        check_pop("t2_pop2", 8'hA2, 2'd0);
        check("t2_req_c", 64'(request), 64'h0);
        grant = 4'b0000;
        tick();
        check("t2_idle_valid", 64'(out_valid), 64'h0);
        check("t2_hold_data",  64'(out_data),  64'hA2);

        // ---- 3: fill ch2, overflow attempt, drain in order ----
        for (int k = 0; k < 4; k++) begin
            set_push(2, 8'hB0 + 8'(k));
            tick();
        end
        check("t3_full_ready", 64'(push_ready), 64'hB);
        set_push(2, 8'hB4);
        tick();
        check("t3_still_full", 64'(push_ready), 64'hB);
        push_valid = 4'b0000;
        grant      = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_pop("t3_pop", 8'hB0 + 8'(k), 2'd2);
            if (k == 0) check("t3_ready_freed", 64'(push_ready), 64'hF);
        end
        check("t3_req_empty", 64'(request), 64'h0);
        grant = 4'b0000;
        tick();

        // ---- 4: illegal grants ----
        push_valid = 4'b0011;
        push_data  = 32'h0000_C1C0;
        tick();
        push_valid = 4'b0000;
        grant      = 4'b0011;
        tick();
        check("t4_multi_gerr",  64'(grant_err), 64'h1);
        check("t4_multi_valid", 64'(out_valid), 64'h0);
        check("t4_multi_req",   64'(request),   64'h3);
        grant = 4'b1000;
        tick();
        check("t4_empty_gerr",  64'(grant_err), 64'h1);
        check("t4_empty_valid", 64'(out_valid), 64'h0);
        grant = 4'b0000;
        tick();
        check("t4_gerr_clear", 64'(grant_err), 64'h0);
        grant = 4'b0001;
        tick();
        check_pop("t4_ch0", 8'hC0, 2'd0);
        grant = 4'b0010;
        tick();
        check_pop("t4_ch1", 8'hC1, 2'd1);
        check("t4_req_empty", 64'(request), 64'h0);
        grant = 4'b0000;

        // ---- 5: simultaneous push and pop on ch1 ----
        set_push(1, 8'hD0);
        tick();
        set_push(1, 8'h5C);
        grant = 4'b0010;
        tick();
        check_pop("t5_old", 8'hD0, 2'd1);
        check("t5_req_kept", 64'(request), 64'h2);
        push_valid = 4'b0000;
        tick();
        check_pop("t5_new", 8'h5C, 2'd1);
        check("t5_req_empty", 64'(request), 64'h0);
        grant = 4'b0000;
        tick();

        // ---- full queue with push and pop together: only the pop happens ----
        for (int k = 0; k < 4; k++) begin
            set_push(3, 8'hE0 + 8'(k));
            tick();
        end
        set_push(3, 8'hE4);
        grant = 4'b1000;
        tick();
        check_pop("tf_pop0", 8'hE0, 2'd3);
        check("tf_ready_freed", 64'(push_ready), 64'hF);
        push_valid = 4'b0000;
        for (int k = 1; k < 4; k++) begin
            tick();
            check_pop("tf_pop", 8'hE0 + 8'(k), 2'd3);
        end
        check("tf_req_empty", 64'(request), 64'h0);
        grant = 4'b0000;
        tick();
`ifdef WRR_QUEUE_STATS_EN
        check("stats_ch3", 64'(pop_count[63:48]), 64'd4);
        check("stats_ch0", 64'(pop_count[15:0]),  64'd3);
`endif

        // ---- 6: reset mid-stream ----
        push_valid = 4'b1001;
        push_data  = 32'hF300_00F0;
        tick();
        push_valid = 4'b0000;
        grant      = 4'b0001;
        reset      = 1'b1;
        tick();
        check("t6_rst_valid", 64'(out_valid),  64'h0);
        check("t6_rst_req",   64'(request),    64'h0);
        check("t6_rst_ready", 64'(push_ready), 64'h0);
        check("t6_rst_data",  64'(out_data),   64'h0);
`ifdef WRR_QUEUE_STATS_EN
        check("t6_rst_stats", 64'(pop_count), 64'h0);
`endif
        reset = 1'b0;
        grant = 4'b1000;
        tick();
        check("t6_post_gerr",  64'(grant_err), 64'h1);
        check("t6_post_valid", 64'(out_valid), 64'h0);
        check("t6_post_req",   64'(request),   64'h0);
        grant = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
